// File: rtl/serial_rx_in_pkg.sv
// Shared definitions for the serial_rx_in UART receiver.
package serial_rx_in_pkg;

  localparam int FRAME_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/serial_rx_sync.sv
// Two-flop synchronizer for the asynchronous rxd line; resets to the idle (high) level.
module serial_rx_sync (
  input  logic m_clock,
  input  logic p_reset,
  input  logic d_i,
  output logic q_o
);

  logic stage1_q;
  logic stage2_q;

  // Shift the raw input through two flops so only a settled value reaches the FSM.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      stage1_q <= 1'b1;
      stage2_q <= 1'b1;
    end else begin
      stage1_q <= d_i;
      stage2_q <= stage1_q;
    end
  end

  assign q_o = stage2_q;

endmodule

// File: rtl/serial_rx_in.sv
// 8N1 UART receiver: mid-bit sampling, sticky rxready flag, one-cycle done pulse.
module serial_rx_in
  import serial_rx_in_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic       rxd,
  input  logic       port_read,
  output logic       rxready,
  output logic [7:0] data,
  output logic       done
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);

  logic rxs;

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cyc_q, cyc_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  rxready_q, rxready_d;
  logic                  complete;

  serial_rx_sync u_sync (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .d_i     (rxd),
    .q_o     (rxs)
  );

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      rxready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      rxready_q <= rxready_d;
    end
  end

  // Frame sequencing: start bit checked at its mid-point, then every BAUD_DIV cycles after that.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q + CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    complete = 1'b0;

    case (state_q)
      IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        if (!rxs) begin
          state_d = START;
        end
      end
      START: begin
        if (cyc_q == HALF_LAST) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cyc_q == FULL_LAST) begin
          cyc_d   = '0;
          shift_d = {rxs, shift_q[FRAME_BITS-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cyc_q == FULL_LAST) begin
          cyc_d = '0;
          if (rxs) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cyc_d = '0;
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: begin
        cyc_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output update: a completing byte always wins over a simultaneous port_read.
  always_comb begin
    data_d    = complete ? shift_q : data_q;
    done_d    = complete;
    rxready_d = complete | (rxready_q & ~port_read);
  end

  assign data    = data_q;
  assign done    = done_q;
  assign rxready = rxready_q;

endmodule

// File: tb/tb_serial_rx_in.sv
// Directed testbench for serial_rx_in at BAUD_DIV=16.
module tb_serial_rx_in;

  localparam int BAUD = 16;
  localparam int DONE_LATENCY = 2 + BAUD / 2 + 9 * BAUD + 1;

  logic       m_clock;
  logic       p_reset;
  logic       rxd;
  logic       portRead;
  logic       rxready;
  logic [7:0] data;
  logic       done;

  int checkCount = 0;
  int errorCount = 0;
  int cycleCnt   = 0;
  int lastStart  = 0;
  logic prevDone = 1'b0;

  logic [7:0] doneDataQ[$];
  int         doneCycleQ[$];

  serial_rx_in #(.BAUD_DIV(BAUD)) dut (
    .m_clock   (m_clock),
    .p_reset   (p_reset),
    .rxd       (rxd),
    .port_read (portRead),
    .rxready   (rxready),
    .data      (data),
    .done      (done)
  );

  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  // Free-running cycle stamp used to measure done latency.
  always @(posedge m_clock) cycleCnt <= cycleCnt + 1;

  // Record every done pulse with its data and cycle stamp; flag back-to-back pulses.
  always @(negedge m_clock) begin
    if (done) begin
      doneDataQ.push_back(data);
      doneCycleQ.push_back(cycleCnt);
    end
    if (done && prevDone) checkOutput("doneTwoCycles", 32'd1, 32'd0);
    prevDone = done;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge m_clock);
      #1;
    end
  endtask

  // Drive one 8N1 frame starting now; optionally raise port_read in the stop-bit sampling cycle.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input bit readAtStop);
    logic bitVal;
    lastStart = cycleCnt;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      bitVal = 1'b0;
      else if (i == 9) bitVal = stopBit;
      else             bitVal = b[i-1];
      for (int c = 0; c < BAUD; c++) begin
        rxd      = bitVal;
        portRead = readAtStop && (i == 9) && (c == 10);
        @(posedge m_clock);
        #1;
      end
    end
    portRead = 1'b0;
  endtask

  task automatic pulseRead();
    portRead = 1'b1;
    @(posedge m_clock);
    #1;
    portRead = 1'b0;
  endtask

  // Bound the whole run so a stuck design cannot hang the simulation.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    p_reset  = 1'b0;
    rxd      = 1'b1;
    portRead = 1'b0;

    // Reset held while rxd toggles: outputs stay at reset values.
    for (int i = 0; i < 12; i++) begin
      @(posedge m_clock);
      #1;
      rxd = ~rxd;
      if (i % 4 == 3) begin
        checkOutput("resetData", data, 8'h00);
        checkOutput("resetDone", done, 1'b0);
        checkOutput("resetRxready", rxready, 1'b0);
      end
    end
    rxd = 1'b1;
    p_reset = 1'b1;
    waitCycles(8);
    checkOutput("relData", data, 8'h00);
    checkOutput("relDone", done, 1'b0);
    checkOutput("relRxready", rxready, 1'b0);

    // Single byte 0x41 with exact done latency.
    base = doneDataQ.size();
    applyStimulus(8'h41, 1'b1, 1'b0);
    waitCycles(4);
    checkOutput("singleCount", doneDataQ.size() - base, 1);
    if (doneDataQ.size() > base) begin
      checkOutput("singleLatency", doneCycleQ[base] - lastStart, DONE_LATENCY);
      checkOutput("singleDoneData", doneDataQ[base], 8'h41);
    end
    checkOutput("singleData", data, 8'h41);
    waitCycles(20);
    checkOutput("singleHeld", rxready, 1'b1);
    pulseRead();
    checkOutput("singleCleared", rxready, 1'b0);
    checkOutput("singleDataKept", data, 8'h41);

    // Back-to-back "Hi\n" with a single stop bit each.
    waitCycles(5);
    base = doneDataQ.size();
    applyStimulus(8'h48, 1'b1, 1'b0);
    applyStimulus(8'h69, 1'b1, 1'b0);
    applyStimulus(8'h0A, 1'b1, 1'b0);
    waitCycles(4);
    checkOutput("b2bCount", doneDataQ.size() - base, 3);
    if (doneDataQ.size() >= base + 3) begin
      checkOutput("b2bByte0", doneDataQ[base], 8'h48);
      checkOutput("b2bByte1", doneDataQ[base+1], 8'h69);
      checkOutput("b2bByte2", doneDataQ[base+2], 8'h0A);
      checkOutput("b2bSpacing01", doneCycleQ[base+1] - doneCycleQ[base], 10 * BAUD);
      checkOutput("b2bSpacing12", doneCycleQ[base+2] - doneCycleQ[base+1], 10 * BAUD);
    end
    pulseRead();

    // Three-cycle glitch is rejected, then 0x55 arrives normally.
    waitCycles(5);
    base = doneDataQ.size();
    rxd = 1'b0;
    waitCycles(3);
    rxd = 1'b1;
    waitCycles(30);
    checkOutput("glitchNoDone", doneDataQ.size() - base, 0);
    checkOutput("glitchRxready", rxready, 1'b0);
    applyStimulus(8'h55, 1'b1, 1'b0);
    waitCycles(4);
    checkOutput("afterGlitchCount", doneDataQ.size() - base, 1);
    checkOutput("afterGlitchData", data, 8'h55);
    pulseRead();

    // Framing error on 0xA5 followed by a break, then 0x3C.
    waitCycles(5);
    base = doneDataQ.size();
    applyStimulus(8'hA5, 1'b0, 1'b0);
    rxd = 1'b0;
    waitCycles(2 * BAUD);
    checkOutput("frameErrNoDone", doneDataQ.size() - base, 0);
    checkOutput("frameErrData", data, 8'h55);
    checkOutput("frameErrRxready", rxready, 1'b0);
    rxd = 1'b1;
    waitCycles(BAUD);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    waitCycles(4);
    checkOutput("frameErrCount", doneDataQ.size() - base, 1);
    checkOutput("frameErrNewData", data, 8'h3C);
    pulseRead();

    // Overrun: 0x11 unread, then 0x22 completes while port_read is high.
    waitCycles(5);
    base = doneDataQ.size();
    applyStimulus(8'h11, 1'b1, 1'b0);
    waitCycles(4);
    checkOutput("overrunFirst", data, 8'h11);
    checkOutput("overrunReady1", rxready, 1'b1);
    applyStimulus(8'h22, 1'b1, 1'b1);
    waitCycles(4);
    checkOutput("overrunCount", doneDataQ.size() - base, 2);
    checkOutput("overrunData", data, 8'h22);
    checkOutput("overrunReady2", rxready, 1'b1);
    pulseRead();
    checkOutput("overrunCleared", rxready, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/serial_rx_in.md
Name: serial_rx_in

Overview:
Asynchronous serial (UART, 8N1) receiver. It deserializes a bit stream on rxd into bytes and pulses done when a byte completes. It holds the byte on data with an rxready flag until the consumer acknowledges with port_read. It is used as the simulation-side monitor of the system TXD line, and as the RX channel of the system serial port.

Parameters:
BAUD_DIV, 16, m_clock cycles per serial bit; must equal the divisor of the transmitter driving rxd; even, >= 4.

Ports:
m_clock  in  1  system clock; all state changes on its rising edge.
p_reset  in  1  asynchronous, active-low reset.
rxd  in  1  serial input; idle high; asynchronous to m_clock.
port_read  in  1  consumer acknowledge; while high it clears rxready.
rxready  out  1  byte available on data; sticky until port_read.
data  out  8  last correctly framed byte received.
done  out  1  one-cycle pulse in the cycle data is updated with a new byte.

Behaviour:
- Reset (p_reset=0, asynchronous): state=IDLE; data=8'h00; done=0; rxready=0; both synchronizer flops=1; bit counter=0; cycle counter=0.
- rxd passes through a 2-flop synchronizer; rxs is the second flop. Only rxs is used internally.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: rxs=0 -> START, cycle counter cleared.
- START: when the counter reaches BAUD_DIV/2-1, sample rxs.
  - rxs=0 -> DATA, counters cleared.
  - rxs=1 (glitch) -> IDLE; nothing reported.
- DATA: sample rxs every BAUD_DIV cycles, measured from the start-bit mid-point. 8 samples, LSB first, shifted into a shift register. After the 8th sample -> STOP.
- STOP: sample rxs BAUD_DIV cycles after the last data sample.
  - rxs=1: data <= shift register, done=1 for exactly one cycle, rxready=1; -> IDLE.
  - rxs=0 (framing error): byte discarded; data, rxready and done unchanged; -> WAIT_IDLE.
- WAIT_IDLE: stay until rxs=1, then -> IDLE. Prevents false starts on a break.
- Latency: rxd falling edge at cycle 0 means the synchronized edge is seen at cycle 2. done is high in cycle 2 + BAUD_DIV/2 + 9*BAUD_DIV + 1, and data is valid in that same cycle.
- done is registered and never high on two consecutive cycles.
- rxready:
  - set on a good stop bit;
  - cleared on any cycle with port_read=1 and no simultaneous completion;
  - if port_read and a completion occur in the same cycle, rxready=1 (the new byte wins).
  - port_read while rxready=0 has no effect.
- Overrun: a new byte completing while rxready=1 overwrites data, pulses done, and leaves rxready=1. No error is flagged.
- Back-to-back frames: a new start bit is accepted in the cycle after returning to IDLE, so a one-bit stop is sufficient.
- Reset asserted mid-frame aborts the frame immediately and restores all reset values; the next start is searched only after reset release.
- Counters are sized to hold BAUD_DIV-1 and 0..8; no wrap is visible externally.

Decomposition:
- Shared package: state enum (IDLE, START, DATA, STOP, WAIT_IDLE) and FRAME_BITS=8.
- One natural sub-module: serial_rx_sync, the 2-flop synchronizer with reset value 1. Everything else stays in one module.

Test Plan:
- Reset: hold p_reset=0 with rxd toggling -> data=00, done=0, rxready=0 throughout. Release -> outputs unchanged while rxd=1.
- Single byte: send 8'h41 (start, 1,0,0,0,0,0,1,0, stop) at BAUD_DIV=16 -> done pulses once at cycle 2+8+144+1=155 after the start edge; data=41; rxready=1 held until port_read, then 0 the next cycle.
- Back-to-back: send "Hi\n" (48,69,0A) with one stop bit each -> three done pulses, data sequence 48,69,0A, no lost bytes.
- Glitch: rxd low for 3 cycles then high -> no done, state returns to IDLE. A following 8'h55 is received correctly.
- Framing error: send 8'hA5 with stop=0, then rxd low for 2 bit times, then high, then 8'h3C -> no done for A5; data=3C with one done pulse.
- Overrun and simultaneous read: receive 11 without port_read, then 22 with port_read asserted in the completion cycle of 22 -> data=22, rxready stays 1. A later port_read clears it.
